da_sample_sequencer: RTL and testbench

- Control unit for the bit-serial distributed-arithmetic FIR datapath (subfilter chain plus adder tree).
- Accepts one parallel sample per valid/ready handshake and drives the datapath's parallel load, bit-serial enable and sign-bit strobes for WORD_WIDTH cycles.
- Captures the filter result on the sign-bit cycle and presents it on a valid/ready output port.
- Sits between the sample source and the datapath; its `filter_en`/`x_we`/`ts` connect directly to every subfilter.

---
 rtl/da_sample_sequencer.sv | 144 ++++++++++++++
 tb/tb_da_sample_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/da_sample_sequencer.sv
// da_sample_sequencer: control FSM for the bit-serial DA FIR datapath.
// Takes one sample per in_valid/in_ready handshake, then drives x_we,
// filter_en, ts and bit_idx for WORD_WIDTH serial cycles. It captures
// acc_in on the sign-bit cycle and offers it on y/y_valid/y_ready.
// Ports:
//   clk, rst (sync, active high), en (global run enable)
//   in_valid/in_ready/x_in : sample input handshake
//   x, x_we, filter_en, ts, bit_idx : datapath control
//   acc_in : datapath sum; y/y_valid/y_ready : result handshake
//   busy : high while LOAD/ACCUM/SIGN
module da_sample_sequencer #(
  parameter int WORD_WIDTH = 16,
  parameter int CNT_WIDTH  = $clog2(WORD_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] x_in,
  output logic [WORD_WIDTH-1:0] x,
  output logic                  x_we,
  output logic                  filter_en,
  output logic                  ts,
  output logic [CNT_WIDTH-1:0]  bit_idx,
  input  logic [WORD_WIDTH-1:0] acc_in,
  output logic [WORD_WIDTH-1:0] y,
  output logic                  y_valid,
  input  logic                  y_ready,
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ACCUM,
    S_SIGN,
    S_OUT
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST =
    CNT_WIDTH'(WORD_WIDTH - 2);
  localparam logic [CNT_WIDTH-1:0] CNT_SIGN =
    CNT_WIDTH'(WORD_WIDTH - 1);

  state_t               state;
  state_t               state_nxt;
  state_t               st_dec;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 accept;

  assign accept = in_valid & in_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (accept) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (en) state_nxt = S_ACCUM;
      end
      S_ACCUM: begin
        if (en && cnt == CNT_LAST) state_nxt = S_SIGN;
      end
      S_SIGN: begin
        if (en) state_nxt = S_OUT;
      end
      S_OUT: begin
        // Leaving OUT needs only y_ready; a new sample also needs en.
        if (y_ready) state_nxt = accept ? S_LOAD : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Sample, result and bit counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      x   <= '0;
      y   <= '0;
      cnt <= '0;
    end else begin
      if (accept) x <= x_in;
      if (state == S_LOAD && en) begin
        cnt <= '0;
      end else if (state == S_ACCUM && en) begin
        cnt <= cnt + 1'b1;
      end
      if (state == S_SIGN && en) y <= acc_in;
    end
  end

  // Output decode; during the reset cycle everything decodes as IDLE
  // so no strobe can fire while the machine is being cleared.
  always_comb begin
    st_dec    = rst ? S_IDLE : state;
    in_ready  = 1'b0;
    x_we      = 1'b0;
    filter_en = 1'b0;
    ts        = 1'b0;
    bit_idx   = '0;
    y_valid   = 1'b0;
    busy      = 1'b0;
    unique case (st_dec)
      S_IDLE: begin
        in_ready = en & ~rst;
      end
      S_LOAD: begin
        x_we = en;
        busy = 1'b1;
      end
      S_ACCUM: begin
        filter_en = en;
        bit_idx   = cnt;
        busy      = 1'b1;
      end
      S_SIGN: begin
        filter_en = en;
        ts        = en;
        bit_idx   = CNT_SIGN;
        busy      = 1'b1;
      end
      S_OUT: begin
        y_valid  = 1'b1;
        in_ready = en & y_ready;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_da_sample_sequencer.sv
// tb_da_sample_sequencer: table vectors, directed sequences and
// random stimulus checked against a phase-count reference model.
module tb_da_sample_sequencer;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0;
  logic         in_valid = 1'b0;
  logic         y_ready = 1'b0;
  logic [W-1:0] x_in = '0;
  logic [W-1:0] acc_in = '0;
  logic         in_ready, x_we, filter_en, ts, y_valid, busy;
  logic [3:0]   bit_idx;
  logic [W-1:0] x, y;

  da_sample_sequencer #(.WORD_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .en(en),
    .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in),
    .x(x), .x_we(x_we), .filter_en(filter_en), .ts(ts),
    .bit_idx(bit_idx), .acc_in(acc_in), .y(y),
    .y_valid(y_valid), .y_ready(y_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  int cyc = 0;

  // Reference model: progress count since acceptance.
  // 0 = load, 1..W = serial bits (W = sign), W+1 = result held.
  bit           m_act = 1'b0;
  int           m_p = 0;
  logic [W-1:0] m_x = '0;
  logic [W-1:0] m_y = '0;

  logic         o_ir, o_we, o_fe, o_ts, o_yv, o_bu;
  logic [3:0]   o_bi;
  logic [W-1:0] o_x, o_y;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    logic e_ir, e_we, e_fe, e_ts, e_yv, e_bu;
    logic [3:0] e_bi;
    bit oph;
    #4;
    oph  = !rst && m_act && m_p == W + 1;
    e_ir = !rst && en && (!m_act || (oph && y_ready));
    e_we = !rst && m_act && m_p == 0 && en;
    e_fe = !rst && m_act && m_p >= 1 && m_p <= W && en;
    e_ts = !rst && m_act && m_p == W && en;
    e_bi = (!rst && m_act && m_p >= 1 && m_p <= W) ?
           4'(m_p - 1) : 4'd0;
    e_yv = oph;
    e_bu = !rst && m_act && m_p <= W;
    check($sformatf("cycle%0d", cyc),
      {22'd0, in_ready, x_we, filter_en, ts, bit_idx, y_valid,
       busy, x, y},
      {22'd0, e_ir, e_we, e_fe, e_ts, e_bi, e_yv, e_bu, m_x, m_y});
    o_ir = in_ready; o_we = x_we; o_fe = filter_en; o_ts = ts;
    o_bi = bit_idx; o_yv = y_valid; o_bu = busy; o_x = x; o_y = y;
    if (rst) begin
      m_act = 1'b0; m_p = 0; m_x = '0; m_y = '0;
    end else if (in_valid && e_ir) begin
      m_x = x_in; m_act = 1'b1; m_p = 0;
    end else if (oph) begin
      if (y_ready) m_act = 1'b0;
    end else if (m_act && en) begin
      if (m_p == W) m_y = acc_in;
      m_p++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // One sample from IDLE to result handshake; k counts cycles after
  // the accepting edge (k=0 is the load cycle).
  task automatic run_sample(input logic [W-1:0] xv,
                            input int en_lo, input int en_hi,
                            input int acc_k, input logic [W-1:0] accv,
                            output int lat, output int nwe,
                            output int nfe, output int nts,
                            output int bad, output int held7,
                            output logic [W-1:0] yv);
    int exp_bi;
    lat = -1; nwe = 0; nfe = 0; nts = 0; bad = 0; held7 = 0;
    yv = '0; exp_bi = 0;
    rst = 1'b0; en = 1'b1; y_ready = 1'b1;
    in_valid = 1'b1; x_in = xv; acc_in = '0;
    step();
    check("accept", 64'(o_ir), 64'd1);
    in_valid = 1'b0;
    for (int k = 0; k < 60; k++) begin
      en = !(k >= en_lo && k <= en_hi);
      acc_in = (k == acc_k) ? accv : (16'hDEAD ^ 16'(k));
      step();
      nwe += int'(o_we); nfe += int'(o_fe); nts += int'(o_ts);
      if (o_fe) begin
        if (o_bi != 4'(exp_bi)) bad++;
        exp_bi++;
      end
      if (o_ts && !o_fe) bad++;
      if (!en && o_fe) bad++;
      if (!en && o_bi == 4'd7) held7++;
      if (o_yv) begin
        lat = k; yv = o_y;
        break;
      end
    end
    en = 1'b1;
  endtask

  typedef struct {
    logic         rst, en, iv;
    logic [W-1:0] xi;
    logic         e_ir, e_bu, e_we, e_fe;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int lat, nwe, nfe, nts, bad, held7;
    logic [W-1:0] yv;
    int acc_t[3];
    int nacc, npulse, nir, nbad;
    logic [W-1:0] xs[3];
    logic [W-1:0] yhold;

    tbl[0] = '{1'b1, 1'b1, 1'b1, 16'hAAAA, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 16'hAAAA, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 16'hAAAA, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 16'hAAAA, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 16'h8001, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[7] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0};

    // Unchecked power-on reset so registers are defined.
    rst = 1'b1;
    @(posedge clk);
    #1;

    y_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      rst = tbl[i].rst; en = tbl[i].en;
      in_valid = tbl[i].iv; x_in = tbl[i].xi;
      step();
      check($sformatf("tbl%0d", i),
        {60'd0, o_ir, o_bu, o_we, o_fe},
        {60'd0, tbl[i].e_ir, tbl[i].e_bu, tbl[i].e_we, tbl[i].e_fe});
    end
    rst = 1'b0; in_valid = 1'b0;

    // Single sample
    run_sample(16'h8001, -1, -2, 16, 16'h1234,
               lat, nwe, nfe, nts, bad, held7, yv);
    check("single_lat", 64'(lat), 64'd17);
    check("single_we", 64'(nwe), 64'd1);
    check("single_fe", 64'(nfe), 64'd16);
    check("single_ts", 64'(nts), 64'd1);
    check("single_bi", 64'(bad), 64'd0);
    check("single_y", 64'(yv), 64'h1234);

    // Back-to-back
    xs[0] = 16'h0001; xs[1] = 16'h0002; xs[2] = 16'h0003;
    nacc = 0; npulse = 0; nir = 0;
    en = 1'b1; y_ready = 1'b1; in_valid = 1'b1; x_in = xs[0];
    for (int c = 0; c < 100; c++) begin
      step();
      nir += int'(o_ir);
      if (o_yv) npulse++;
      if (o_ir && in_valid) begin
        acc_t[nacc] = cyc;
        nacc++;
        if (nacc == 3) in_valid = 1'b0;
        else x_in = xs[nacc];
      end
      if (nacc == 3 && npulse == 3) break;
    end
    check("b2b_nacc", 64'(nacc), 64'd3);
    check("b2b_pulses", 64'(npulse), 64'd3);
    check("b2b_gap1", 64'(acc_t[1] - acc_t[0]), 64'd18);
    check("b2b_gap2", 64'(acc_t[2] - acc_t[1]), 64'd18);
    check("b2b_inready", 64'(nir), 64'd4);

    // Output stall then direct reload
    y_ready = 1'b0; in_valid = 1'b1; x_in = 16'h4321;
    acc_in = 16'hBEEF;
    for (int c = 0; c < 40; c++) begin
      step();
      if (o_yv) break;
    end
    check("stall_yv", 64'(o_yv), 64'd1);
    yhold = o_y;
    x_in = 16'h7777;
    nbad = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (!o_yv || o_y !== yhold || o_ir || o_we) nbad++;
    end
    check("stall_hold", 64'(nbad), 64'd0);
    check("stall_y", 64'(yhold), 64'hBEEF);
    y_ready = 1'b1;
    step();
    check("stall_hs", 64'(o_ir), 64'd1);
    in_valid = 1'b0;
    step();
    check("stall_load", {62'd0, o_we, o_bu}, 64'd3);
    check("stall_x", 64'(o_x), 64'h7777);
    for (int c = 0; c < 20; c++) step();

    // en dropped at bit 7
    run_sample(16'h1111, 8, 12, 21, 16'hC0DE,
               lat, nwe, nfe, nts, bad, held7, yv);
    check("engate_lat", 64'(lat), 64'd22);
    check("engate_fe", 64'(nfe), 64'd16);
    check("engate_held", 64'(held7), 64'd5);
    check("engate_bad", 64'(bad), 64'd0);
    check("engate_y", 64'(yv), 64'hC0DE);

    // en dropped in sign cycle
    run_sample(16'h2222, 16, 18, 19, 16'h5A5A,
               lat, nwe, nfe, nts, bad, held7, yv);
    check("ensign_lat", 64'(lat), 64'd20);
    check("ensign_ts", 64'(nts), 64'd1);
    check("ensign_fe", 64'(nfe), 64'd16);
    check("ensign_y", 64'(yv), 64'h5A5A);

    // Reset mid-ACCUM at bit 9
    en = 1'b1; y_ready = 1'b1; in_valid = 1'b1; x_in = 16'h3333;
    step();
    in_valid = 1'b0;
    for (int k = 0; k <= 10; k++) step();
    check("rst_bi9", 64'(o_bi), 64'd9);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    check("rst_after",
      {26'd0, o_we, o_fe, o_ts, o_yv, o_bu, o_y, o_x},
      64'd0);
    run_sample(16'h4444, -1, -2, 16, 16'h0F0F,
               lat, nwe, nfe, nts, bad, held7, yv);
    check("rst_next_lat", 64'(lat), 64'd17);
    check("rst_next_bi", 64'(bad), 64'd0);
    check("rst_next_y", 64'(yv), 64'h0F0F);

    // Random
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      en = ($urandom_range(0, 7) != 0);
      in_valid = 1'($urandom_range(0, 1));
      y_ready = ($urandom_range(0, 3) != 0);
      x_in = 16'($urandom);
      acc_in = 16'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
